// File: rtl/mdu_hilo_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Results are computed at launch and committed after a fixed busy period.
module mdu_hilo_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic [31:0]   pending_hi;
   logic [31:0]   pending_lo;
   logic          pending_we;

   logic          is_div;
   logic          is_signed;
   logic          neg_a;
   logic          neg_b;
   logic          div_zero;
   logic [63:0]   ext_a;
   logic [63:0]   ext_b;
   logic [63:0]   prod;
   logic [31:0]   mag_a;
   logic [31:0]   mag_b;
   logic [31:0]   dvs;
   logic [31:0]   q_u;
   logic [31:0]   r_u;
   logic [31:0]   div_q;
   logic [31:0]   div_r;
   logic [63:0]   result;

   assign is_div    = op[1];
   assign is_signed = ~op[0];
   assign neg_a     = is_signed & src_a[31];
   assign neg_b     = is_signed & src_b[31];
   assign div_zero  = (src_b == 32'd0);

   // Sign-extending to 64 bits lets one multiplier serve mult and multu.
   assign ext_a = {{32{neg_a}}, src_a};
   assign ext_b = {{32{neg_b}}, src_b};
   assign prod  = ext_a * ext_b;

   assign mag_a = neg_a ? (32'd0 - src_a) : src_a;
   assign mag_b = neg_b ? (32'd0 - src_b) : src_b;
   assign dvs   = div_zero ? 32'd1 : mag_b;
   assign q_u   = mag_a / dvs;
   assign r_u   = mag_a % dvs;
   assign div_q = (neg_a ^ neg_b) ? (32'd0 - q_u) : q_u;
   assign div_r = neg_a ? (32'd0 - r_u) : r_u;

   assign result    = is_div ? {div_r, div_q} : prod;
   assign stall_req = busy | start;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         hi         <= 32'd0;
         lo         <= 32'd0;
         count      <= '0;
         pending_hi <= 32'd0;
         pending_lo <= 32'd0;
         pending_we <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  pending_hi <= result[63:32];
                  pending_lo <= result[31:0];
                  pending_we <= ~(is_div & div_zero);
                  count      <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                  busy       <= 1'b1;
                  state      <= BUSY;
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            BUSY: begin
               if (count == CW'(1)) begin
                  if (pending_we) begin
                     hi <= pending_hi;
                     lo <= pending_lo;
                  end
                  busy  <= 1'b0;
                  count <= '0;
                  state <= IDLE;
               end else begin
                  count <= count - CW'(1);
               end
            end
         endcase
      end
   end

endmodule
